// File: rtl/vlc_pkg.sv
// rtl/vlc_pkg.sv - shared widths and FSM state for the VLC bitstream packer
package vlc_pkg;

    localparam int VLC_CODE_W = 32;
    localparam int VLC_LEN_W  = 6;
    localparam int VLC_WORD_W = 32;
    localparam int VLC_ACC_W  = 2 * VLC_WORD_W;
    localparam int VLC_FILL_W = 7;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } vlc_state_e;

endpackage

// File: rtl/vlc_shift_merge.sv
// rtl/vlc_shift_merge.sv - masks a codeword and ORs it MSB-first below the accumulator's valid bits
module vlc_shift_merge
    import vlc_pkg::*;
(
    input  logic [VLC_ACC_W-1:0]  acc_i,
    input  logic [VLC_FILL_W-1:0] fill_i,
    input  logic [VLC_CODE_W-1:0] code_i,
    input  logic [VLC_LEN_W-1:0]  len_i,
    output logic [VLC_ACC_W-1:0]  merged_o,
    output logic [VLC_FILL_W-1:0] nf_o
);

    logic [VLC_CODE_W:0]   mask;
    logic [VLC_CODE_W-1:0] masked;
    logic [VLC_FILL_W-1:0] shamt;

    // Only meaningful for 1 <= len_i <= 32 and fill_i < 32, so shamt stays within 1..63.
    always_comb begin
        mask     = (33'd1 << len_i) - 33'd1;
        masked   = code_i & mask[VLC_CODE_W-1:0];
        shamt    = 7'd64 - fill_i - {1'b0, len_i};
        merged_o = acc_i | ({32'd0, masked} << shamt);
        nf_o     = fill_i + {1'b0, len_i};
    end

endmodule

// File: rtl/vlc_bitstream_packer.sv
// rtl/vlc_bitstream_packer.sv - packs variable-length codewords into 32-bit big-endian words with slice flush
module vlc_bitstream_packer
    import vlc_pkg::*;
#(
    parameter int CODE_W = VLC_CODE_W,
    parameter int LEN_W  = VLC_LEN_W,
    parameter int CNT_W  = 24
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [CODE_W-1:0] in_code,
    input  logic [LEN_W-1:0]  in_len,
    input  logic              flush,
    output logic              out_valid,
    output logic [31:0]       out_word,
    output logic              out_last,
    output logic [2:0]        out_nbytes,
    output logic              flush_done,
    output logic [CNT_W-1:0]  slice_bits,
    output logic              err_len
);

    vlc_state_e            state_q;
    logic [VLC_ACC_W-1:0]  acc_q;
    logic [VLC_FILL_W-1:0] fill_q;
    logic [CNT_W-1:0]      count_q;

    logic [VLC_ACC_W-1:0]  merged_d;
    logic [VLC_FILL_W-1:0] nf_d;
    logic [VLC_FILL_W-1:0] fill_round;
    logic                  len_ok;
    logic                  accept;

    vlc_shift_merge u_shift_merge (
        .acc_i    (acc_q),
        .fill_i   (fill_q),
        .code_i   (in_code),
        .len_i    (in_len),
        .merged_o (merged_d),
        .nf_o     (nf_d)
    );

    always_comb begin
        len_ok     = (in_len != '0) && (in_len <= LEN_W'(32));
        accept     = in_valid && len_ok && (state_q == RUN);
        fill_round = fill_q + 7'd7;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RUN;
            acc_q      <= '0;
            fill_q     <= '0;
            count_q    <= '0;
            out_valid  <= 1'b0;
            out_word   <= '0;
            out_last   <= 1'b0;
            out_nbytes <= '0;
            flush_done <= 1'b0;
            slice_bits <= '0;
            err_len    <= 1'b0;
        end else begin
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_nbytes <= '0;
            out_word   <= '0;
            flush_done <= 1'b0;
            case (state_q)
                RUN: begin
                    if (in_valid && (in_len > LEN_W'(32))) begin
                        err_len <= 1'b1;
                    end
                    if (accept) begin
                        count_q <= count_q + {{(CNT_W-LEN_W){1'b0}}, in_len};
                        if (nf_d >= 7'd32) begin
                            out_valid  <= 1'b1;
                            out_word   <= merged_d[63:32];
                            out_nbytes <= 3'd4;
                            acc_q      <= {merged_d[31:0], 32'd0};
                            fill_q     <= nf_d - 7'd32;
                        end else begin
                            acc_q  <= merged_d;
                            fill_q <= nf_d;
                        end
                    end
                    if (flush) begin
                        state_q <= FLUSH;
                    end
                end
                FLUSH: begin
                    // Anything arriving during the drain cycle is lost; flag it for the host.
                    if (in_valid) begin
                        err_len <= 1'b1;
                    end
                    if (fill_q != '0) begin
                        out_valid  <= 1'b1;
                        out_last   <= 1'b1;
                        out_word   <= acc_q[63:32];
                        out_nbytes <= fill_round[5:3];
                    end
                    flush_done <= 1'b1;
                    slice_bits <= count_q;
                    acc_q      <= '0;
                    fill_q     <= '0;
                    count_q    <= '0;
                    state_q    <= RUN;
                end
                default: state_q <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_vlc_bitstream_packer.sv
// tb/tb_vlc_bitstream_packer.sv - randomized and directed bench with a bit-queue reference model
module tb_vlc_bitstream_packer;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic [31:0] in_code;
    logic [5:0]  in_len;
    logic        flush;
    logic        out_valid;
    logic [31:0] out_word;
    logic        out_last;
    logic [2:0]  out_nbytes;
    logic        flush_done;
    logic [23:0] slice_bits;
    logic        err_len;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the slice is a plain queue of bits in coded order.
    bit          mq[$];
    int unsigned mcnt;
    bit          mflush;
    bit          merr;
    logic [23:0] mslice;

    logic        exp_valid;
    logic [31:0] exp_word;
    logic        exp_last;
    logic [2:0]  exp_nbytes;
    logic        exp_done;

    vlc_bitstream_packer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_code    (in_code),
        .in_len     (in_len),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_word   (out_word),
        .out_last   (out_last),
        .out_nbytes (out_nbytes),
        .flush_done (flush_done),
        .slice_bits (slice_bits),
        .err_len    (err_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mcnt   = 0;
        mflush = 1'b0;
        merr   = 1'b0;
        mslice = '0;
    endtask

    task automatic model_step(input logic v, input logic [31:0] code, input logic [5:0] len, input logic fl);
        int n;
        exp_valid  = 1'b0;
        exp_word   = '0;
        exp_last   = 1'b0;
        exp_nbytes = '0;
        exp_done   = 1'b0;
        if (mflush) begin
            if (v) merr = 1'b1;
            n = mq.size();
            if (n > 0) begin
                exp_valid  = 1'b1;
                exp_last   = 1'b1;
                exp_nbytes = 3'((n + 7) / 8);
                for (int i = 0; i < 32; i++) exp_word[31-i] = (i < n) ? mq[i] : 1'b0;
            end
            exp_done = 1'b1;
            mslice   = mcnt[23:0];
            mq.delete();
            mcnt   = 0;
            mflush = 1'b0;
        end else begin
            if (v && len > 32) merr = 1'b1;
            if (v && len != 0 && len <= 32) begin
                for (int i = int'(len) - 1; i >= 0; i--) mq.push_back(code[i]);
                mcnt = (mcnt + len) & 32'h00FF_FFFF;
            end
            if (mq.size() >= 32) begin
                exp_valid  = 1'b1;
                exp_nbytes = 3'd4;
                for (int i = 0; i < 32; i++) exp_word[31-i] = mq.pop_front();
            end
            if (fl) mflush = 1'b1;
        end
    endtask

    task automatic step(input logic v, input logic [31:0] code, input logic [5:0] len, input logic fl);
        in_valid = v;
        in_code  = code;
        in_len   = len;
        flush    = fl;
        model_step(v, code, len, fl);
        @(posedge clk);
        #1;
        check("out_valid", out_valid, exp_valid);
        if (exp_valid) begin
            check("out_word", out_word, exp_word);
            check("out_last", out_last, exp_last);
            check("out_nbytes", out_nbytes, exp_nbytes);
        end
        check("flush_done", flush_done, exp_done);
        check("slice_bits", slice_bits, mslice);
        check("err_len", err_len, merr);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_word"}, out_word, 0);
        check({tag, "_last"}, out_last, 0);
        check({tag, "_nbytes"}, out_nbytes, 0);
        check({tag, "_done"}, flush_done, 0);
        check({tag, "_slice"}, slice_bits, 0);
        check({tag, "_err"}, err_len, 0);
    endtask

    initial begin
        logic        v;
        logic        fl;
        logic [5:0]  len;
        int          r;

        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_code  = '0;
        in_len   = '0;
        flush    = 1'b0;
        model_reset();
        #2;
        check_reset_outputs("rst");
        @(posedge clk);
        #3 reset_n = 1'b1;

        // 1: 3 + 29 bits complete a word exactly
        step(1, 32'h5, 6'd3, 0);
        step(1, 32'h1FFF_FFFF, 6'd29, 0);
        check("t1_word", out_word, 32'hBFFF_FFFF);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        check("t1_nolast", out_valid, 0);

        // 2: 40 bits then flush
        step(1, 32'hAABBCC, 6'd24, 0);
        step(1, 32'hDDEE, 6'd16, 1);
        check("t2_word0", out_word, 32'hAABB_CCDD);
        step(0, 0, 0, 0);
        check("t2_word1", out_word, 32'hEE00_0000);
        check("t2_last", out_last, 1);
        check("t2_nbytes", out_nbytes, 1);
        check("t2_slice", slice_bits, 40);

        // 3: full words every cycle
        for (int i = 0; i < 4; i++) begin
            step(1, 32'h1234_5678, 6'd32, 0);
            check("t3_word", out_word, 32'h1234_5678);
        end
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        check("t3_slice", slice_bits, 128);

        // 4: code with flush in the same cycle, upper bits masked
        step(1, 32'hFFFF_FFFF, 6'd3, 1);
        step(0, 0, 0, 0);
        check("t4_word", out_word, 32'hE000_0000);
        check("t4_nbytes", out_nbytes, 1);
        check("t4_slice", slice_bits, 3);

        // 5: len 0 ignored, len 40 flagged, empty flush
        step(1, 32'hFFFF_FFFF, 6'd0, 0);
        step(1, 32'hFFFF_FFFF, 6'd40, 0);
        check("t5_err", err_len, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        check("t5_done", flush_done, 1);
        check("t5_slice", slice_bits, 0);

        // 6: asynchronous reset with 17 bits pending
        step(1, 32'h1ABCD, 6'd17, 0);
        reset_n = 1'b0;
        #2;
        check_reset_outputs("t6_rst");
        model_reset();
        @(posedge clk);
        #3 reset_n = 1'b1;
        step(1, 32'h1, 6'd1, 1);
        step(0, 0, 0, 0);
        check("t6_word", out_word, 32'h8000_0000);
        check("t6_slice", slice_bits, 1);

        // Random traffic; out-of-range lengths and flush-cycle inputs appear occasionally
        for (int c = 0; c < 600; c++) begin
            r  = int'($urandom_range(0, 99));
            v  = ($urandom_range(0, 9) < 8);
            fl = ($urandom_range(0, 19) == 0);
            if (r < 4)      len = 6'd0;
            else if (r < 6) len = 6'($urandom_range(33, 63));
            else if (r < 20) len = 6'd32;
            else            len = 6'($urandom_range(1, 31));
            step(v, $urandom, len, fl);
        end
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
